// File: rtl/vga_copper_pkg.sv
// Shared types and constants for the raster-synchronised copper list.
package vga_copper_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StFetch,
        StWait,
        StExec
    } state_e;

    // Bit positions inside the CPU-visible 32-bit list word.
    localparam int unsigned LINE_LSB = 0;
    localparam int unsigned LINE_MSB = 9;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned VAL_LSB  = 24;
    localparam int unsigned END_BIT  = 31;

    localparam int unsigned ENTRY_LINE_W = LINE_MSB - LINE_LSB + 1;

    localparam logic [5:0] REG_BG_COLOR = 6'h30;
    localparam logic [5:0] REG_FG_COLOR = 6'h31;

    // 23-bit stored form of one command.
    typedef struct packed {
        logic                    last;
        logic [5:0]              value;
        logic [5:0]              addr;
        logic [ENTRY_LINE_W-1:0] line;
    } entry_t;

    function automatic logic is_color_reg(input logic [5:0] addr);
        return (addr == REG_BG_COLOR) || (addr == REG_FG_COLOR);
    endfunction

endpackage

// File: rtl/vga_copper_list.sv
// Copper command storage: one synchronous write port, one asynchronous read port.
module vga_copper_list
    import vga_copper_pkg::*;
#(
    parameter int unsigned ENTRIES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_i,
    input  logic [$clog2(ENTRIES)-1:0] widx_i,
    input  entry_t                     wdata_i,
    input  logic [$clog2(ENTRIES)-1:0] ridx_i,
    output entry_t                     rdata_o
);

    entry_t mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (wr_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    // Read of the pre-edge contents gives the old entry on a same-cycle write.
    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/vga_copper.sv
// Replays a CPU-loaded (line, reg, value) list into the colour registers each frame.
// Optional end-of-list interrupt when VGA_COPPER_IRQ_EN is defined.
module vga_copper
    import vga_copper_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned LINE_W  = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       list_wr_i,
    input  logic [$clog2(ENTRIES)-1:0] list_idx_i,
    input  logic [31:0]                list_data_i,
    input  logic                       enable_i,
    input  logic                       cpu_reg_wr_i,
    input  logic [5:0]                 cpu_reg_addr_i,
    input  logic [5:0]                 cpu_reg_data_i,
    input  logic [LINE_W-1:0]          vga_y_i,
    input  logic                       vga_blank_i,
    input  logic                       frame_start_i,
    output logic                       reg_wr_o,
    output logic [5:0]                 reg_addr_o,
    output logic [5:0]                 reg_data_o,
    output logic                       busy_o,
    output logic [$clog2(ENTRIES)-1:0] ptr_o,
    output logic                       irq_o,
    input  logic                       irq_clr_i
);

    localparam int unsigned IdxW = $clog2(ENTRIES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(ENTRIES - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    entry_t          entry_q, entry_d;
    entry_t          wr_entry, rd_entry;
    logic            line_hit, exec_fire, cop_wr;
    logic            reg_wr_q, reg_wr_d;
    logic [5:0]      reg_addr_q, reg_addr_d, reg_data_q, reg_data_d;

    assign wr_entry = '{
        last:  list_data_i[END_BIT],
        value: list_data_i[VAL_LSB+:6],
        addr:  list_data_i[ADDR_LSB+:6],
        line:  list_data_i[LINE_MSB:LINE_LSB]
    };

    logic unused_list_bits;
    assign unused_list_bits = ^{list_data_i[15:10], list_data_i[23:22], list_data_i[30]};

    vga_copper_list #(
        .ENTRIES(ENTRIES)
    ) u_list (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_i   (list_wr_i),
        .widx_i (list_idx_i),
        .wdata_i(wr_entry),
        .ridx_i (ptr_q),
        .rdata_o(rd_entry)
    );

    assign line_hit = vga_blank_i && (vga_y_i >= LINE_W'(entry_q.line));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        entry_d   = entry_q;
        exec_fire = 1'b0;
        if (!enable_i) begin
            state_d = StIdle;
        end else if (state_q != StIdle && frame_start_i) begin
            // Frame restart aborts whatever is in flight, including an EXEC write.
            ptr_d   = '0;
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StHalt;
                StHalt:  state_d = StHalt;
                StFetch: begin
                    entry_d = rd_entry;
                    state_d = StWait;
                end
                StWait:  if (line_hit) state_d = StExec;
                StExec: begin
                    // A coincident CPU write takes the port; retry next cycle.
                    if (!cpu_reg_wr_i) begin
                        exec_fire = 1'b1;
                        if (entry_q.last || ptr_q == LastIdx) begin
                            state_d = StHalt;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            state_d = StFetch;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign cop_wr = exec_fire && is_color_reg(entry_q.addr);

    always_comb begin
        reg_wr_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        if (cpu_reg_wr_i) begin
            reg_wr_d   = 1'b1;
            reg_addr_d = cpu_reg_addr_i;
            reg_data_d = cpu_reg_data_i;
        end else if (cop_wr) begin
            reg_wr_d   = 1'b1;
            reg_addr_d = entry_q.addr;
            reg_data_d = entry_q.value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            entry_q    <= '0;
            reg_wr_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            entry_q    <= entry_d;
            reg_wr_q   <= reg_wr_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
        end
    end

    assign reg_wr_o   = reg_wr_q;
    assign reg_addr_o = reg_addr_q;
    assign reg_data_o = reg_data_q;
    assign ptr_o      = ptr_q;
    assign busy_o     = (state_q == StFetch) || (state_q == StWait) || (state_q == StExec);

`ifdef VGA_COPPER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (irq_clr_i) begin
            irq_q <= 1'b0;
        end else if (exec_fire && entry_q.last) begin
            irq_q <= 1'b1;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr_i;
    assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_vga_copper.sv
// Directed bench for vga_copper: per-cycle vector table plus hand-written corner sequences.
module tb_vga_copper;

`ifdef VGA_COPPER_IRQ_EN
    localparam logic IrqOn = 1'b1;
`else
    localparam logic IrqOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        list_wr_i;
    logic [2:0]  list_idx_i;
    logic [31:0] list_data_i;
    logic        enable_i;
    logic        cpu_reg_wr_i;
    logic [5:0]  cpu_reg_addr_i;
    logic [5:0]  cpu_reg_data_i;
    logic [9:0]  vga_y_i;
    logic        vga_blank_i;
    logic        frame_start_i;
    logic        reg_wr_o;
    logic [5:0]  reg_addr_o;
    logic [5:0]  reg_data_o;
    logic        busy_o;
    logic [2:0]  ptr_o;
    logic        irq_o;
    logic        irq_clr_i;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    vga_copper #(
        .ENTRIES(8),
        .LINE_W (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .list_wr_i     (list_wr_i),
        .list_idx_i    (list_idx_i),
        .list_data_i   (list_data_i),
        .enable_i      (enable_i),
        .cpu_reg_wr_i  (cpu_reg_wr_i),
        .cpu_reg_addr_i(cpu_reg_addr_i),
        .cpu_reg_data_i(cpu_reg_data_i),
        .vga_y_i       (vga_y_i),
        .vga_blank_i   (vga_blank_i),
        .frame_start_i (frame_start_i),
        .reg_wr_o      (reg_wr_o),
        .reg_addr_o    (reg_addr_o),
        .reg_data_o    (reg_data_o),
        .busy_o        (busy_o),
        .ptr_o         (ptr_o),
        .irq_o         (irq_o),
        .irq_clr_i     (irq_clr_i)
    );

    typedef struct {
        logic       en;
        logic       fs;
        logic [9:0] y;
        logic       blank;
        logic       exp_wr;
        logic [5:0] exp_addr;
        logic [5:0] exp_data;
        logic       exp_busy;
        logic [2:0] exp_ptr;
        logic       exp_irq;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mkv(input logic en, input logic fs, input int y, input logic blank,
                                 input logic wr, input logic [5:0] a, input logic [5:0] d,
                                 input logic busy, input int p, input logic irq);
        vec_t v;
        v.en = en; v.fs = fs; v.y = 10'(y); v.blank = blank;
        v.exp_wr = wr; v.exp_addr = a; v.exp_data = d;
        v.exp_busy = busy; v.exp_ptr = 3'(p); v.exp_irq = irq;
        return v;
    endfunction

    // Unused word bits are set so a decoder using the wrong field would misbehave.
    function automatic logic [31:0] mkw(input int line, input logic [5:0] a, input logic [5:0] d,
                                        input logic e);
        logic [31:0] w;
        w        = '0;
        w[9:0]   = 10'(line);
        w[15:10] = 6'h2A;
        w[21:16] = a;
        w[29:24] = d;
        w[30]    = 1'b1;
        w[31]    = e;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        list_wr_i   = 1'b1;
        list_idx_i  = 3'(idx);
        list_data_i = w;
        step();
        list_wr_i = 1'b0;
    endtask

    task automatic chk_wr(input string name, input logic [5:0] a, input logic [5:0] d);
        chk({name, ".wr"}, 32'(reg_wr_o), 32'd1);
        chk({name, ".addr"}, 32'(reg_addr_o), 32'(a));
        chk({name, ".data"}, 32'(reg_data_o), 32'(d));
    endtask

    initial begin
        rst_n = 1'b0; list_wr_i = 1'b0; list_idx_i = '0; list_data_i = '0;
        enable_i = 1'b1; cpu_reg_wr_i = 1'b0; cpu_reg_addr_i = '0; cpu_reg_data_i = '0;
        vga_y_i = '0; vga_blank_i = 1'b1; frame_start_i = 1'b0; irq_clr_i = 1'b0;

        // Reset holds everything quiet even with enable and frame_start active.
        for (int i = 0; i < 4; i++) begin
            frame_start_i = i[0];
            step();
            chk("rst.wr", 32'(reg_wr_o), 32'd0);
            chk("rst.busy", 32'(busy_o), 32'd0);
            chk("rst.ptr", 32'(ptr_o), 32'd0);
            chk("rst.irq", 32'(irq_o), 32'd0);
        end
        frame_start_i = 1'b0;
        enable_i = 1'b0;
        vga_blank_i = 1'b0;
        rst_n = 1'b1;
        step();
        load(0, mkw(100, 6'h30, 6'h05, 1'b0));
        load(1, mkw(200, 6'h31, 6'h2A, 1'b1));

        // Two-entry frame: writes at line 100 and 200 only during blank, then HALT at ptr 1.
        vecs[0]  = mkv(1, 0,   0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        vecs[1]  = mkv(1, 1,   0, 0, 0, 6'h00, 6'h00, 1, 0, 0);
        vecs[2]  = mkv(1, 0,   0, 0, 0, 6'h00, 6'h00, 1, 0, 0);
        vecs[3]  = mkv(1, 0,  50, 1, 0, 6'h00, 6'h00, 1, 0, 0);
        vecs[4]  = mkv(1, 0, 100, 0, 0, 6'h00, 6'h00, 1, 0, 0);
        vecs[5]  = mkv(1, 0, 100, 1, 0, 6'h00, 6'h00, 1, 0, 0);
        vecs[6]  = mkv(1, 0, 100, 1, 1, 6'h30, 6'h05, 1, 1, 0);
        vecs[7]  = mkv(1, 0, 100, 1, 0, 6'h00, 6'h00, 1, 1, 0);
        vecs[8]  = mkv(1, 0, 150, 1, 0, 6'h00, 6'h00, 1, 1, 0);
        vecs[9]  = mkv(1, 0, 200, 0, 0, 6'h00, 6'h00, 1, 1, 0);
        vecs[10] = mkv(1, 0, 200, 1, 0, 6'h00, 6'h00, 1, 1, 0);
        vecs[11] = mkv(1, 0, 200, 1, 1, 6'h31, 6'h2A, 0, 1, 1);
        vecs[12] = mkv(1, 0, 300, 1, 0, 6'h00, 6'h00, 0, 1, 1);
        vecs[13] = mkv(1, 0, 300, 1, 0, 6'h00, 6'h00, 0, 1, 1);

        for (int i = 0; i < 14; i++) begin
            enable_i = vecs[i].en; frame_start_i = vecs[i].fs;
            vga_y_i = vecs[i].y; vga_blank_i = vecs[i].blank;
            step();
            chk($sformatf("vec%0d.wr", i), 32'(reg_wr_o), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr) begin
                chk($sformatf("vec%0d.addr", i), 32'(reg_addr_o), 32'(vecs[i].exp_addr));
                chk($sformatf("vec%0d.data", i), 32'(reg_data_o), 32'(vecs[i].exp_data));
            end
            chk($sformatf("vec%0d.busy", i), 32'(busy_o), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d.ptr", i), 32'(ptr_o), 32'(vecs[i].exp_ptr));
            chk($sformatf("vec%0d.irq", i), 32'(irq_o), 32'(vecs[i].exp_irq & IrqOn));
        end

        // All eight slots at line 50: one write every 3 cycles, entry 3 filtered,
        // entry 5 rewritten during its own FETCH (old contents must be used).
        for (int i = 0; i < 8; i++) begin
            load(i, mkw(50, (i == 3) ? 6'h10 : ((i % 2) ? 6'h31 : 6'h30), 6'(i * 5 + 1), 1'b0));
        end
        vga_y_i = 10'd50; vga_blank_i = 1'b1; frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
        chk("b.fetch.ptr", 32'(ptr_o), 32'd0);
        chk("b.fetch.busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                list_wr_i = 1'b1; list_idx_i = 3'd5; list_data_i = mkw(50, 6'h31, 6'h3C, 1'b1);
            end
            step();
            list_wr_i = 1'b0;
            chk($sformatf("b%0d.wait.wr", i), 32'(reg_wr_o), 32'd0);
            step();
            chk($sformatf("b%0d.exec.wr", i), 32'(reg_wr_o), 32'd0);
            step();
            chk($sformatf("b%0d.wr", i), 32'(reg_wr_o), 32'(i != 3));
            if (i != 3) begin
                chk($sformatf("b%0d.addr", i), 32'(reg_addr_o), (i % 2) ? 32'h31 : 32'h30);
                chk($sformatf("b%0d.data", i), 32'(reg_data_o), 32'(i * 5 + 1));
            end
            chk($sformatf("b%0d.ptr", i), 32'(ptr_o), (i == 7) ? 32'd7 : 32'(i + 1));
            chk($sformatf("b%0d.busy", i), 32'(busy_o), 32'(i != 7));
        end
        step();
        chk("b.halt.wr", 32'(reg_wr_o), 32'd0);
        chk("b.halt.ptr", 32'(ptr_o), 32'd7);

        // CPU write coinciding with EXEC: CPU first, deferred copper write next cycle.
        load(0, mkw(10, 6'h30, 6'h11, 1'b1));
        vga_y_i = 10'd10; frame_start_i = 1'b1; irq_clr_i = 1'b1;
        step();
        frame_start_i = 1'b0; irq_clr_i = 1'b0;
        chk("c.fetch.ptr", 32'(ptr_o), 32'd0);
        chk("c.irq.clr", 32'(irq_o), 32'd0);
        step();
        step();
        chk("c.exec.wr", 32'(reg_wr_o), 32'd0);
        cpu_reg_wr_i = 1'b1; cpu_reg_addr_i = 6'h31; cpu_reg_data_i = 6'h3F;
        step();
        cpu_reg_wr_i = 1'b0;
        chk_wr("c.cpu", 6'h31, 6'h3F);
        chk("c.cpu.busy", 32'(busy_o), 32'd1);
        step();
        chk_wr("c.cop", 6'h30, 6'h11);
        chk("c.cop.busy", 32'(busy_o), 32'd0);
        chk("c.cop.irq", 32'(irq_o), 32'(IrqOn));
        step();
        chk("c.after.wr", 32'(reg_wr_o), 32'd0);

        // frame_start during EXEC aborts the write; enable drop in WAIT goes IDLE.
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
        step();
        step();
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
        chk("d.abort.wr", 32'(reg_wr_o), 32'd0);
        chk("d.abort.ptr", 32'(ptr_o), 32'd0);
        chk("d.abort.busy", 32'(busy_o), 32'd1);
        step();
        chk("d.wait.busy", 32'(busy_o), 32'd1);
        enable_i = 1'b0;
        step();
        chk("d.idle.busy", 32'(busy_o), 32'd0);
        chk("d.idle.wr", 32'(reg_wr_o), 32'd0);
        step();
        step();
        chk("d.idle2.wr", 32'(reg_wr_o), 32'd0);
        chk("d.irq.held", 32'(irq_o), 32'(IrqOn));

        // irq_clr in the same cycle as an END execution wins over the set.
        enable_i = 1'b1;
        step();
        chk("e.halt.busy", 32'(busy_o), 32'd0);
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
        step();
        step();
        irq_clr_i = 1'b1;
        step();
        irq_clr_i = 1'b0;
        chk_wr("e.cop", 6'h30, 6'h11);
        chk("e.irq.clr", 32'(irq_o), 32'd0);
        step();
        chk("e.irq.stay", 32'(irq_o), 32'd0);

        // CPU writes pass through while the copper is disabled.
        enable_i = 1'b0;
        cpu_reg_wr_i = 1'b1; cpu_reg_addr_i = 6'h30; cpu_reg_data_i = 6'h07;
        step();
        cpu_reg_wr_i = 1'b0;
        chk_wr("f.cpu", 6'h30, 6'h07);
        step();
        chk("f.after.wr", 32'(reg_wr_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
